// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// One byte per grant, with a watchdog that frees the transmitter if done never arrives.
module uart_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DATA_W-1:0]    i_data,
  output logic [N_REQ-1:0]           o_ack,
  output logic [DATA_W-1:0]          o_tx_data,
  output logic                       o_tx_enable,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic                       o_timeout
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int TW   = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t           state, state_nx;
  logic [ID_W-1:0]  last, pick, idx;
  logic             pick_vld;
  logic [TW-1:0]    timer;
  logic             expire;
  logic [N_REQ-1:0] ack_nx;
  logic             en_nx, to_nx;

  // First requester at or after last+1, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last;
    idx      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(last) + i) % N_REQ);
      if (!pick_vld && i_req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Timer holds 1 on the edge where it reaches zero.
  assign expire = (TIMEOUT_CYCLES != 0) && (timer == TW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (pick_vld) state_nx = START;
      START:     state_nx = WAIT_DONE;
      WAIT_DONE: if (i_tx_done || expire) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack_nx = '0;
    en_nx  = 1'b0;
    to_nx  = 1'b0;
    case (state)
      IDLE:      if (pick_vld) ack_nx[pick] = 1'b1;
      START:     en_nx = 1'b1;
      WAIT_DONE: to_nx = !i_tx_done && expire;
      default:   ;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack       <= '0;
      o_tx_enable <= 1'b0;
      o_timeout   <= 1'b0;
      o_tx_data   <= '0;
      o_grant_id  <= '0;
      last        <= ID_W'(N_REQ - 1);
      timer       <= '0;
    end else begin
      o_ack       <= ack_nx;
      o_tx_enable <= en_nx;
      o_timeout   <= to_nx;
      if (state == IDLE && pick_vld) begin
        o_tx_data  <= i_data[pick*DATA_W +: DATA_W];
        o_grant_id <= pick;
      end
      if (state == WAIT_DONE && state_nx == IDLE) last <= o_grant_id;
      if (state == START)                            timer <= TW'(TIMEOUT_CYCLES);
      else if (state == WAIT_DONE && timer != '0)    timer <= timer - TW'(1);
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against an edge-timeline model of the arbiter.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int TO = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic            done;
  logic [N-1:0]    o_ack;
  logic [DW-1:0]   o_tx_data;
  logic            o_tx_enable, o_busy, o_timeout;
  logic [1:0]      o_grant_id;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_ack(o_ack), .o_tx_data(o_tx_data), .o_tx_enable(o_tx_enable),
    .i_tx_done(done), .o_busy(o_busy), .o_grant_id(o_grant_id), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  int ack_cnt = 0, en_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transfer is a timeline of edge indices (grant, enable = grant+1, end).
  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int i = 1; i <= N; i++)
      if (r[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  int            m_n = 0, m_g_edge, m_e_edge, m_last, m_gid, m_pick;
  bit            m_act;
  logic [DW-1:0] m_dat;
  logic [N-1:0]  m_ack;
  bit            m_en, m_to;

  always_comb m_pick = rr_pick(req, m_last);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0; m_last <= N - 1; m_gid <= 0; m_dat <= '0;
      m_ack <= '0; m_en <= 1'b0; m_to <= 1'b0; m_g_edge <= -1000; m_e_edge <= -1000;
    end else begin
      m_n   <= m_n + 1;
      m_ack <= '0; m_en <= 1'b0; m_to <= 1'b0;
      if (!m_act) begin
        if (m_pick >= 0) begin
          m_act <= 1'b1; m_g_edge <= m_n; m_gid <= m_pick;
          m_dat <= data[m_pick*DW +: DW];
          m_ack <= N'(1) << m_pick;
        end
      end else if (m_n == m_g_edge + 1) begin
        m_en <= 1'b1; m_e_edge <= m_n;
      end else if (done) begin
        m_act <= 1'b0; m_last <= m_gid;
      end else if (m_n - m_e_edge >= TO) begin
        m_to <= 1'b1; m_act <= 1'b0; m_last <= m_gid;
      end
    end
  end

  always @(negedge clk) begin
    chk("ack",       o_ack,       m_ack);
    chk("tx_enable", o_tx_enable, m_en);
    chk("timeout",   o_timeout,   m_to);
    chk("busy",      o_busy,      m_act);
    chk("tx_data",   o_tx_data,   m_dat);
    chk("grant_id",  o_grant_id,  m_gid);
    if (|o_ack)      ack_cnt++;
    if (o_tx_enable) en_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack();
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (|o_ack) ok = 1'b1;
    end
    if (!ok) chk("ack_wait", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    int a0, e0, k, cnt, sel, dly;
    int eg[4], ed[4], gg[4], gd[4];
    bit ok;
    rst = 1'b1; req = '0; data = '0; done = 1'b0;
    repeat (3) tick();
    chk("rst_ack", o_ack, 0); chk("rst_en", o_tx_enable, 0); chk("rst_data", o_tx_data, 0);
    chk("rst_busy", o_busy, 0); chk("rst_gid", o_grant_id, 0); chk("rst_to", o_timeout, 0);
    rst = 1'b0;

    // T1 single transfer, done 10 clocks after enable
    req = 3'b001; data[7:0] = 8'hA5; a0 = ack_cnt; e0 = en_cnt;
    wait_ack();
    chk("t1_ack", o_ack, 3'b001); chk("t1_data", o_tx_data, 8'hA5);
    chk("t1_gid", o_grant_id, 0); chk("t1_en_early", o_tx_enable, 0);
    req = '0;
    tick(); chk("t1_en", o_tx_enable, 1);
    repeat (9) tick();
    chk("t1_busy", o_busy, 1);
    done = 1'b1; tick(); done = 1'b0;
    chk("t1_idle", o_busy, 0);
    tick(); chk("t1_acks", ack_cnt - a0, 1); chk("t1_ens", en_cnt - e0, 1);

    // T2 contention from reset
    do_reset();
    eg = '{0, 1, 0, 1}; ed = '{8'h11, 8'h22, 8'h11, 8'h22};
    req = 3'b011; data = {8'h00, 8'h22, 8'h11};
    for (int j = 0; j < 4; j++) begin
      wait_ack();
      gg[j] = int'(o_grant_id); gd[j] = int'(o_tx_data);
      if (j == 3) req = '0;
      tick(); repeat (2) tick();
      done = 1'b1; tick(); done = 1'b0;
    end
    for (int j = 0; j < 4; j++) begin
      chk("t2_gid", gg[j], eg[j]); chk("t2_data", gd[j], ed[j]);
    end

    // T6 back-to-back on requester 0
    req = 3'b001; data[7:0] = 8'h3E;
    wait_ack(); tick(); tick();
    done = 1'b1; tick(); done = 1'b0;
    chk("t6_d_busy", o_busy, 0); chk("t6_d_ack", o_ack, 0);
    tick(); chk("t6_d1_ack", o_ack, 3'b001);
    req = '0;
    tick(); chk("t6_d2_en", o_tx_enable, 1);
    repeat (3) tick(); done = 1'b1; tick(); done = 1'b0;

    // T3 watchdog, then next request served normally
    req = 3'b010; data[15:8] = 8'h3C;
    wait_ack(); chk("t3_gid", o_grant_id, 1);
    tick(); chk("t3_en", o_tx_enable, 1);
    k = 0; ok = 1'b0;
    while (k < 80 && !ok) begin tick(); k++; ok = o_timeout; end
    chk("t3_to_latency", k, 50); chk("t3_to_busy", o_busy, 0);
    wait_ack(); chk("t3_next_gid", o_grant_id, 1); chk("t3_next_data", o_tx_data, 8'h3C);
    req = '0; tick(); tick();
    done = 1'b1; tick(); done = 1'b0;
    chk("t3_end_busy", o_busy, 0);

    // T5 stray done in IDLE, then done coincident with expiry
    done = 1'b1; tick(); done = 1'b0;
    chk("t5_stray_busy", o_busy, 0);
    tick(); chk("t5_stray_ack", o_ack, 0); chk("t5_stray_en", o_tx_enable, 0);
    req = 3'b100; data[23:16] = 8'h77;
    wait_ack(); req = '0; tick();
    repeat (49) tick();
    done = 1'b1; tick(); done = 1'b0;
    chk("t5_sim_to", o_timeout, 0); chk("t5_sim_busy", o_busy, 0);
    tick(); chk("t5_sim_to2", o_timeout, 0);

    // T4 asynchronous reset in WAIT_DONE
    req = 3'b010; data[15:8] = 8'h5A;
    wait_ack(); tick(); repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("t4_ack", o_ack, 0); chk("t4_en", o_tx_enable, 0); chk("t4_data", o_tx_data, 0);
    chk("t4_busy", o_busy, 0); chk("t4_gid", o_grant_id, 0); chk("t4_to", o_timeout, 0);
    tick(); rst = 1'b0; req = 3'b011;
    wait_ack(); chk("t4_first_gid", o_grant_id, 0); chk("t4_first_ack", o_ack, 3'b001);
    req = '0; tick(); tick();
    done = 1'b1; tick(); done = 1'b0;

    // Randomized traffic with an emulated transmitter
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      done = 1'b0;
      if (o_tx_enable) begin
        sel = $urandom_range(0, 9);
        dly = (sel == 0) ? 0 : (sel == 1) ? 50 : (sel == 2) ? 51 : $urandom_range(1, 12);
        if (dly == 1) begin done = 1'b1; cnt = 0; end
        else cnt = (dly == 0) ? 0 : dly - 1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) done = 1'b1;
      end else if ($urandom_range(0, 99) < 3) done = 1'b1;
      for (int r = 0; r < N; r++) begin
        if (o_ack[r]) begin
          req[r] = 1'($urandom_range(0, 1)); data[r*DW +: DW] = 8'($urandom);
        end else if (req[r]) begin
          if ($urandom_range(0, 99) < 2) req[r] = 1'b0;
        end else if ($urandom_range(0, 99) < 25) begin
          req[r] = 1'b1; data[r*DW +: DW] = 8'($urandom);
        end
      end
    end
    req = '0; done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin tick(); ok = !o_busy; end
    chk("drain_idle", ok, 1);
    tick(); tick();
    chk("bytes_vs_acks", en_cnt, ack_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
